// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-bundle bit positions, default stage widths
// and a constant-evaluable clog2 used to size pointers and counters.
package cpu_pkg;

  localparam int BR_ZERO = 0;
  localparam int BR_NEG  = 1;
  localparam int JUMPMEM = 2;
  localparam int JUMP    = 3;
  localparam int PC2REG  = 4;
  localparam int MEM2REG = 5;
  localparam int REGWRT  = 6;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 7;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_fifo_mem.sv
// Entry storage for the stage buffer: DEPTH registers, one synchronous write
// port, one asynchronous read port, cleared by synchronous reset.
module pipe_fifo_mem #(
  parameter int DEPTH = 2,
  parameter int AW    = 1,
  parameter int DW    = 39
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // next-state of the storage array: only the addressed entry changes
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // storage registers with synchronous clear
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pipe_stage_buff.sv
// Elastic valid/ready pipeline register holding DEPTH entries of data plus
// control, with synchronous flush and a saturating stall-cycle counter.
module pipe_stage_buff
  import cpu_pkg::*;
#(
  parameter int WIDTH      = DATA_W,
  parameter int CTRL_WIDTH = CTRL_W,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [CTRL_WIDTH-1:0]         in_ctrl,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [CTRL_WIDTH-1:0]         out_ctrl,
  output logic [clog2(DEPTH+1)-1:0]     count,
  output logic [CNT_W-1:0]              stall_cycles
);

  localparam int PTR_W   = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int OCC_W   = clog2(DEPTH + 1);
  localparam int ENTRY_W = WIDTH + CTRL_WIDTH;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               push, pop;
  logic [ENTRY_W-1:0] head_entry;

  // DEPTH need not be a power of two, so the wrap is explicit
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // ready depends on registered occupancy only, never on out_ready
  assign in_ready  = !reset && (count_q < OCC_W'(DEPTH));
  assign out_valid = (count_q != '0);

  // handshakes, pointer/occupancy update, flush priority and stall counting
  always_comb begin
    push     = in_valid && in_ready && !flush;
    pop      = out_valid && out_ready && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
    if (out_valid && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // control registers; reset overrides flush, push and pop
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  pipe_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (PTR_W),
    .DW    (ENTRY_W)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data ({in_ctrl, in_data}),
    .rd_addr (rd_ptr_q),
    .rd_data (head_entry)
  );

  // stale storage after a flush must not leak out while empty
  assign out_data     = out_valid ? head_entry[WIDTH-1:0] : '0;
  assign out_ctrl     = out_valid ? head_entry[ENTRY_W-1:WIDTH] : '0;
  assign count        = count_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_buff.sv
// Directed self-checking bench: DEPTH=2 main instance, a CNT_W=4 instance for
// counter saturation and a DEPTH=3 instance for pointer wrap ordering.
module tb_pipe_stage_buff;
  import cpu_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [6:0]  a_in_ctrl, a_out_ctrl;
  logic [1:0]  a_count;
  logic [15:0] a_stall;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [6:0]  b_in_ctrl, b_out_ctrl;
  logic [1:0]  b_count;
  logic [3:0]  b_stall;

  logic        c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
  logic [31:0] c_in_data, c_out_data;
  logic [6:0]  c_in_ctrl, c_out_ctrl;
  logic [1:0]  c_count;
  logic [15:0] c_stall;

  pipe_stage_buff #(.WIDTH(32), .CTRL_WIDTH(7), .DEPTH(2), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_ctrl(a_in_ctrl), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .count(a_count), .stall_cycles(a_stall));

  pipe_stage_buff #(.WIDTH(32), .CTRL_WIDTH(7), .DEPTH(2), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ctrl(b_in_ctrl), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .count(b_count), .stall_cycles(b_stall));

  pipe_stage_buff #(.WIDTH(32), .CTRL_WIDTH(7), .DEPTH(3), .CNT_W(16)) dut_c (
    .clock(clock), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_ctrl(c_in_ctrl), .flush(c_flush),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_ctrl(c_out_ctrl), .count(c_count), .stall_cycles(c_stall));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    a_in_valid = 1'b1; a_in_data = 32'h0000_00EE; a_in_ctrl = 7'h7F;
    a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 32'h0; b_in_ctrl = 7'h0;
    b_flush = 1'b0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = 32'h0; c_in_ctrl = 7'h0;
    c_flush = 1'b0; c_out_ready = 1'b0;

    // reset held two cycles with in_valid asserted
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_count", 32'(a_count), 32'd0);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_out_data", a_out_data, 32'd0);
      chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    end
    chk("rst_out_ctrl", 32'(a_out_ctrl), 32'd0);
    chk("rst_stall", 32'(a_stall), 32'd0);
    reset = 1'b0;
    a_in_valid = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("post_rst_count", 32'(a_count), 32'd0);

    // single push then pop
    a_in_valid = 1'b1; a_in_data = 32'h0000_00A5; a_in_ctrl = 7'h41; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk("single_valid", 32'(a_out_valid), 32'd1);
    chk("single_data", a_out_data, 32'h0000_00A5);
    chk("single_ctrl", 32'(a_out_ctrl), 32'h41);
    chk("single_regwrt", 32'(a_out_ctrl[REGWRT]), 32'd1);
    chk("single_count", 32'(a_count), 32'd1);
    tick();
    chk("single_drain_count", 32'(a_count), 32'd0);
    chk("single_drain_valid", 32'(a_out_valid), 32'd0);
    chk("single_drain_data", a_out_data, 32'd0);

    // fill under stall
    a_out_ready = 1'b0; a_in_ctrl = 7'h00;
    a_in_valid = 1'b1; a_in_data = 32'h11;
    tick();
    a_in_data = 32'h22;
    tick();
    a_in_data = 32'h33;
    chk("fill_in_ready", 32'(a_in_ready), 32'd0);
    chk("fill_count", 32'(a_count), 32'd2);
    tick();
    tick();
    chk("fill_stall3", 32'(a_stall), 32'd3);
    chk("fill_count_held", 32'(a_count), 32'd2);
    chk("fill_head11", a_out_data, 32'h11);
    a_out_ready = 1'b1;
    tick();
    chk("drain_head22", a_out_data, 32'h22);
    chk("drain_count1", 32'(a_count), 32'd1);
    tick();
    chk("drain_head33", a_out_data, 32'h33);
    chk("drain_count_pp", 32'(a_count), 32'd1);
    a_in_valid = 1'b0;
    tick();
    chk("drain_empty", 32'(a_out_valid), 32'd0);
    chk("drain_stall_kept", 32'(a_stall), 32'd3);

    // simultaneous push and pop at count=1
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h11;
    tick();
    a_in_data = 32'h22; a_out_ready = 1'b1;
    tick();
    chk("pp_count", 32'(a_count), 32'd1);
    chk("pp_head", a_out_data, 32'h22);

    // continuous streaming; each value appears the cycle after its push
    for (int k = 3; k <= 100; k++) begin
      a_in_data = 32'(k);
      tick();
      chk("stream_data", a_out_data, 32'(k));
      chk("stream_count", 32'(a_count), 32'd1);
    end
    a_in_valid = 1'b0;
    tick();
    chk("stream_end_count", 32'(a_count), 32'd0);

    // flush with full buffer and a same-cycle push
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h55;
    tick();
    a_in_data = 32'h66;
    tick();
    chk("flush_pre_count", 32'(a_count), 32'd2);
    chk("flush_pre_stall", 32'(a_stall), 32'd4);
    a_flush = 1'b1; a_in_data = 32'h99;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("flush_count", 32'(a_count), 32'd0);
    chk("flush_valid", 32'(a_out_valid), 32'd0);
    chk("flush_data", a_out_data, 32'd0);
    chk("flush_ctrl", 32'(a_out_ctrl), 32'd0);
    chk("flush_stall_kept", 32'(a_stall), 32'd4);
    // flush with room available: the push must still be dropped
    a_in_valid = 1'b1; a_in_data = 32'h77;
    tick();
    chk("flush2_pre_count", 32'(a_count), 32'd1);
    a_flush = 1'b1; a_in_data = 32'h99;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("flush2_count", 32'(a_count), 32'd0);
    tick();
    chk("flush2_no99_valid", 32'(a_out_valid), 32'd0);
    chk("flush2_no99_data", a_out_data, 32'd0);

    // reset mid-operation
    a_in_valid = 1'b1; a_in_data = 32'h12;
    tick();
    a_in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_count", 32'(a_count), 32'd0);
    chk("midrst_stall", 32'(a_stall), 32'd0);
    chk("midrst_data", a_out_data, 32'd0);

    // saturation on the 4-bit counter
    b_in_valid = 1'b1; b_in_data = 32'hB1;
    tick();
    b_in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) chk("sat_mid", 32'(b_stall), 32'd10);
    end
    chk("sat_15", 32'(b_stall), 32'd15);
    tick();
    tick();
    chk("sat_hold", 32'(b_stall), 32'd15);
    chk("sat_head", b_out_data, 32'hB1);

    // DEPTH=3 ordering across pointer wrap
    c_out_ready = 1'b0; c_in_valid = 1'b1; c_in_data = 32'd1;
    tick();
    c_in_data = 32'd2;
    tick();
    chk("d3_count2", 32'(c_count), 32'd2);
    chk("d3_in_ready", 32'(c_in_ready), 32'd1);
    c_out_ready = 1'b1;
    for (int k = 3; k <= 10; k++) begin
      c_in_data = 32'(k);
      tick();
      chk("d3_order", c_out_data, 32'(k - 1));
      chk("d3_count", 32'(c_count), 32'd2);
    end
    c_in_valid = 1'b0;
    tick();
    chk("d3_last", c_out_data, 32'd10);
    tick();
    chk("d3_empty", 32'(c_out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
